// File: rtl/cmac_pkg.sv
// rtl/cmac_pkg.sv - shared width helpers for the complex MAC engine
//
// Purpose: derives the operand width W, counter width G and accumulator
// width AW from the QI/QF/MAX_LEN parameters. Each module declares its own
// packed {re, im} bundles from these widths so that parameter overrides
// resize the bundles consistently.
// Ports: none (package).

package cmac_pkg;

  // Operand component width, sign bit included.
  function automatic int calc_w(input int qi, input int qf);
    return qi + qf;
  endfunction

  // Guard bits needed to sum MAX_LEN products without wrap.
  function automatic int calc_g(input int max_len);
    return $clog2(max_len);
  endfunction

  // Accumulator width: full product (2W), +1 for the re/im combine, +G guard.
  function automatic int calc_aw(input int qi, input int qf, input int max_len);
    return 2 * calc_w(qi, qf) + 1 + calc_g(max_len);
  endfunction

endpackage

// File: rtl/cmac_prod.sv
// rtl/cmac_prod.sv - registered complex product and re/im combine stages
//
// Purpose: S2 registers the four full-precision signed partial products,
// S3 combines them into a complex product of width 2W+1. Valid and last
// travel alongside the data; everything holds while i_en is low.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   i_en                  pipeline advance enable
//   i_valid, i_last       S1 beat qualifiers
//   i_a_re..i_b_im        S1 operands, signed W bits
//   o_valid, o_last       S3 beat qualifiers
//   o_p_re, o_p_im        S3 complex product, signed 2W+1 bits

module cmac_prod #(
  parameter int W = 6,
  localparam int PW = 2 * W + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_en,
  input  logic                 i_valid,
  input  logic                 i_last,
  input  logic signed [W-1:0]  i_a_re,
  input  logic signed [W-1:0]  i_a_im,
  input  logic signed [W-1:0]  i_b_re,
  input  logic signed [W-1:0]  i_b_im,
  output logic                 o_valid,
  output logic                 o_last,
  output logic signed [PW-1:0] o_p_re,
  output logic signed [PW-1:0] o_p_im
);

  logic signed [2*W-1:0] r_rr, r_ii, r_ri, r_ir;
  logic                  r_s2_valid, r_s2_last;
  logic                  r_s3_valid, r_s3_last;
  logic        [PW-1:0]  r_p_re, r_p_im;

  // S2: signed operands sized to 2W by the assignment context, so no bits drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr       <= '0;
      r_ii       <= '0;
      r_ri       <= '0;
      r_ir       <= '0;
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
    end else if (i_en) begin
      r_rr       <= i_a_re * i_b_re;
      r_ii       <= i_a_im * i_b_im;
      r_ri       <= i_a_re * i_b_im;
      r_ir       <= i_a_im * i_b_re;
      r_s2_valid <= i_valid;
      r_s2_last  <= i_last;
    end
  end

  // S3: one extra bit absorbs the carry of the combine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p_re     <= '0;
      r_p_im     <= '0;
      r_s3_valid <= 1'b0;
      r_s3_last  <= 1'b0;
    end else if (i_en) begin
      r_p_re     <= {r_rr[2*W-1], r_rr} - {r_ii[2*W-1], r_ii};
      r_p_im     <= {r_ri[2*W-1], r_ri} + {r_ir[2*W-1], r_ir};
      r_s3_valid <= r_s2_valid;
      r_s3_last  <= r_s2_last;
    end
  end

  assign o_valid = r_s3_valid;
  assign o_last  = r_s3_last;
  assign o_p_re  = r_p_re;
  assign o_p_im  = r_p_im;

endmodule

// File: rtl/cmac_accum.sv
// rtl/cmac_accum.sv - streaming complex multiply-accumulate over framed input
//
// Purpose: accepts complex a/b pairs, multiplies them per beat and sums the
// products over a frame closed by s_last (or force-closed at MAX_LEN beats),
// emitting one full-precision complex result per frame.
// Optional feature macro: CMAC_SAT_EN (saturating accumulator + ovf flag).
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   s_valid, s_ready, s_last     input beat handshake and frame delimiter
//   a_re, a_im, b_re, b_im       signed QI.QF operands
//   m_valid, m_ready             result handshake
//   y_re, y_im                   signed frame sum, 2QF fraction bits
//   len_err, ovf, err_clr        sticky error flags and their clear

module cmac_accum
  import cmac_pkg::*;
#(
  parameter int QI      = 3,
  parameter int QF      = 3,
  parameter int MAX_LEN = 16,
  localparam int W  = calc_w(QI, QF),
  localparam int G  = calc_g(MAX_LEN),
  localparam int AW = calc_aw(QI, QF, MAX_LEN)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 s_last,
  input  logic signed [W-1:0]  a_re,
  input  logic signed [W-1:0]  a_im,
  input  logic signed [W-1:0]  b_re,
  input  logic signed [W-1:0]  b_im,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic signed [AW-1:0] y_re,
  output logic signed [AW-1:0] y_im,
  output logic                 len_err,
  output logic                 ovf,
  input  logic                 err_clr
);

  localparam int PW = 2 * W + 1;
  localparam logic [G:0] CNT_MAX = (G + 1)'(MAX_LEN - 1);

  typedef struct packed { logic [W-1:0]  re; logic [W-1:0]  im; } op_t;
  typedef struct packed { logic [AW-1:0] re; logic [AW-1:0] im; } acc_t;

  logic          w_en, w_accept, w_cap, w_last_in, w_fire;
  logic          w_s3_valid, w_s3_last;
  logic [PW-1:0] w_p_re, w_p_im;
  logic [AW-1:0] w_next_re, w_next_im;
  op_t           r_a, r_b;
  acc_t          r_acc, r_y;
  logic          r_s1_valid, r_s1_last, r_m_valid, r_len_err;
  logic [G:0]    r_cnt;

  // A held result freezes the whole pipe, including input acceptance.
  assign w_en      = !(r_m_valid && !m_ready);
  assign s_ready   = w_en;
  assign w_accept  = s_valid && w_en;
  assign w_cap     = (r_cnt == CNT_MAX);
  assign w_last_in = s_last || w_cap;
  assign w_fire    = w_en && w_s3_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
    end else if (w_en) begin
      r_a        <= '{re: a_re, im: a_im};
      r_b        <= '{re: b_re, im: b_im};
      r_s1_valid <= s_valid;
      r_s1_last  <= w_last_in;
    end
  end

  // Beat counter and overlength flag; a set beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_len_err <= 1'b0;
    end else begin
      if (w_accept) r_cnt <= w_last_in ? '0 : r_cnt + 1'b1;
      if (w_accept && !s_last && w_cap) r_len_err <= 1'b1;
      else if (err_clr)                 r_len_err <= 1'b0;
    end
  end

  cmac_prod #(.W(W)) u_prod (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_en),
    .i_valid (r_s1_valid),
    .i_last  (r_s1_last),
    .i_a_re  (r_a.re),
    .i_a_im  (r_a.im),
    .i_b_re  (r_b.re),
    .i_b_im  (r_b.im),
    .o_valid (w_s3_valid),
    .o_last  (w_s3_last),
    .o_p_re  (w_p_re),
    .o_p_im  (w_p_im)
  );

`ifdef CMAC_SAT_EN
  // One extra bit exposes overflow: top two bits disagree.
  logic [AW:0] w_sum_re, w_sum_im;
  logic        w_ovf_re, w_ovf_im, r_ovf;
  localparam logic [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

  assign w_sum_re  = {r_acc.re[AW-1], r_acc.re} + {{(G+1){w_p_re[PW-1]}}, w_p_re};
  assign w_sum_im  = {r_acc.im[AW-1], r_acc.im} + {{(G+1){w_p_im[PW-1]}}, w_p_im};
  assign w_ovf_re  = w_sum_re[AW] ^ w_sum_re[AW-1];
  assign w_ovf_im  = w_sum_im[AW] ^ w_sum_im[AW-1];
  assign w_next_re = w_ovf_re ? (w_sum_re[AW] ? ACC_MIN : ACC_MAX) : w_sum_re[AW-1:0];
  assign w_next_im = w_ovf_im ? (w_sum_im[AW] ? ACC_MIN : ACC_MAX) : w_sum_im[AW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               r_ovf <= 1'b0;
    else if (w_fire && (w_ovf_re || w_ovf_im)) r_ovf <= 1'b1;
    else if (err_clr)                         r_ovf <= 1'b0;
  end

  assign ovf = r_ovf;
`else
  assign w_next_re = r_acc.re + {{G{w_p_re[PW-1]}}, w_p_re};
  assign w_next_im = r_acc.im + {{G{w_p_im[PW-1]}}, w_p_im};
  assign ovf       = 1'b0;
`endif

  // S4: last beat publishes acc + p and restarts the sum from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_y       <= '0;
      r_m_valid <= 1'b0;
    end else begin
      if (w_fire) begin
        if (w_s3_last) begin
          r_y   <= '{re: w_next_re, im: w_next_im};
          r_acc <= '0;
        end else begin
          r_acc <= '{re: w_next_re, im: w_next_im};
        end
      end
      if (w_fire && w_s3_last) r_m_valid <= 1'b1;
      else if (m_ready)        r_m_valid <= 1'b0;
    end
  end

  assign m_valid = r_m_valid;
  assign y_re    = r_y.re;
  assign y_im    = r_y.im;
  assign len_err = r_len_err;

endmodule
